// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_CSUM = 2'd3
  } state_t;

  localparam int unsigned HDR_BYTES      = 2;
  localparam int unsigned HDR_IDX_W      = $clog2(HDR_BYTES);
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_IDX_W     = $clog2(BYTES_PER_WORD);
  localparam int unsigned WORD_W         = 8 * BYTES_PER_WORD;

endpackage

// File: rtl/imem_word_packer.sv
// Shifts stream bytes MSB-first into a word and raises a one-cycle strobe
// on the cycle after the last byte of each word is accepted.
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        i_byte,
  input  logic              i_valid,
  input  logic              i_clear,
  output logic [WORD_W-1:0] o_word,
  output logic              o_word_valid,
  output logic              o_last_byte_c
);

  logic [BYTE_IDX_W-1:0] r_idx;
  logic [WORD_W-1:0]     r_word;
  logic                  r_word_valid;

  assign o_last_byte_c = (r_idx == BYTE_IDX_W'(BYTES_PER_WORD - 1));
  assign o_word        = r_word;
  assign o_word_valid  = r_word_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx        <= '0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
    end else begin
      r_word_valid <= i_valid && o_last_byte_c && !i_clear;
      if (i_clear) begin
        r_idx <= '0;
      end else if (i_valid) begin
        r_idx <= r_idx + BYTE_IDX_W'(1);
      end
      if (i_valid) begin
        r_word <= {r_word[WORD_W-9:0], i_byte};
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed, XOR-checksummed program into instruction memory
// while holding the CPU frozen.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  state_t                r_state;
  state_t                w_next;
  logic [TO_W-1:0]       r_to_cnt;
  logic [HDR_IDX_W-1:0]  r_hdr_idx;
  logic [15:0]           r_n;
  logic [15:0]           r_words;
  logic [7:0]            r_csum;
  logic [31:0]           r_addr;
  logic                  r_rx_ready;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_error;

  logic                  w_accept;
  logic                  w_to_hit;
  logic [15:0]           w_n;
  logic                  w_last_byte;
  logic                  w_start_load;
  logic                  w_clear;
  logic                  w_set_error;
  logic                  w_done;
  logic [WORD_W-1:0]     w_word;
  logic                  w_word_valid;

  assign w_accept = rx_valid && r_rx_ready;
  assign w_to_hit = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign w_n      = {r_n[7:0], rx_data};

  imem_word_packer u_packer (
    .clk           (clk),
    .reset         (reset),
    .i_byte        (rx_data),
    .i_valid       (w_accept && (r_state == ST_DATA)),
    .i_clear       (w_clear),
    .o_word        (w_word),
    .o_word_valid  (w_word_valid),
    .o_last_byte_c (w_last_byte)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next state and single-cycle control decisions
  always_comb begin
    w_next       = r_state;
    w_start_load = 1'b0;
    w_clear      = 1'b0;
    w_set_error  = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next       = ST_HDR;
          w_start_load = 1'b1;
          w_clear      = 1'b1;
        end
      end
      ST_HDR: begin
        if (w_accept && (r_hdr_idx == HDR_IDX_W'(HDR_BYTES - 1))) begin
          if (32'(w_n) > DEPTH) begin
            w_next      = ST_IDLE;
            w_set_error = 1'b1;
          end else if (w_n == 16'd0) begin
            w_next = ST_CSUM;
          end else begin
            w_next = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (w_accept && w_last_byte && ((r_words + 16'd1) == r_n)) begin
          w_next = ST_CSUM;
        end
      end
      ST_CSUM: begin
        if (w_accept) begin
          w_next = ST_IDLE;
          if (rx_data == r_csum) w_done      = 1'b1;
          else                   w_set_error = 1'b1;
        end
      end
      default: w_next = ST_IDLE;
    endcase
    // An accepted byte always beats the idle timeout
    if ((r_state != ST_IDLE) && !w_accept && w_to_hit) begin
      w_next      = ST_IDLE;
      w_set_error = 1'b1;
      w_clear     = 1'b1;
      w_done      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_to_cnt   <= '0;
      r_hdr_idx  <= '0;
      r_n        <= '0;
      r_words    <= '0;
      r_csum     <= '0;
      r_addr     <= '0;
      r_rx_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) || w_accept) r_to_cnt <= '0;
      else                                  r_to_cnt <= r_to_cnt + TO_W'(1);

      if (w_start_load) begin
        r_hdr_idx <= '0;
        r_words   <= '0;
        r_csum    <= '0;
        r_error   <= 1'b0;
      end

      if (w_accept && (r_state == ST_HDR)) begin
        r_hdr_idx <= r_hdr_idx + HDR_IDX_W'(1);
        r_n       <= w_n;
      end

      if (w_accept && (r_state == ST_DATA)) begin
        r_csum <= r_csum ^ rx_data;
        if (w_last_byte) begin
          r_words <= r_words + 16'd1;
          r_addr  <= 32'({r_words[ADDR_W-1:0], 2'b00});
        end
      end

      if (w_set_error) r_error <= 1'b1;
      r_done     <= w_done;
      r_rx_ready <= (w_next != ST_IDLE);
      r_busy     <= (w_next != ST_IDLE);
    end
  end

  assign rx_ready     = r_rx_ready;
  assign busy         = r_busy;
  assign cpu_hold     = r_busy;
  assign done         = r_done;
  assign error        = r_error;
  assign words_loaded = r_words;
  assign imem_addr    = r_addr;
  assign imem_we      = w_word_valid;
  assign imem_wdata   = w_word;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader against a word/checksum reference model.
module tb_imem_loader;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned TMO    = 16;
  localparam int unsigned DEPTH  = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  int checks = 0;
  int errors = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          done_cnt  = 0;
  int          hold_viol = 0;

  imem_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_hold     (cpu_hold),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  // Record memory writes and watch hold/done relationships mid-cycle
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_wdata);
    end
    if (done === 1'b1) begin
      done_cnt++;
      if (busy !== 1'b0) hold_viol++;
    end
    if (cpu_hold !== busy) hold_viol++;
  end

  function automatic logic [31:0] model_word(input logic [7:0] bytes[$], input int i);
    logic [31:0] w;
    w = 32'd0;
    for (int k = 0; k < 4; k++) w = (w << 8) + 32'(bytes[4*i+k]);
    return w;
  endfunction

  function automatic logic [7:0] model_csum(input logic [7:0] bytes[$]);
    logic [7:0] c;
    c = 8'h00;
    foreach (bytes[i]) c = c ^ bytes[i];
    return c;
  endfunction

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    done_cnt = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1; rx_valid = 1'b0;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic st);
    int n;
    n = 0;
    @(negedge clk); rx_data = b; rx_valid = 1'b1; start = st;
    while (rx_ready !== 1'b1 && n < 40) begin
      @(negedge clk); n++;
    end
    if (rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_byte: rx_ready=%b required 1 within 40 cycles", rx_ready);
    end
    @(posedge clk);
  endtask

  task automatic go_idle();
    @(negedge clk); rx_valid = 1'b0; start = 1'b0;
  endtask

  // gap_mode: 0 none, 1 idle cycle before every byte, 2 random idle cycles
  task automatic run_load(input string name, input logic [7:0] data[$], input int n,
                          input bit bad, input int gap_mode, input bit start_mid);
    logic [7:0] cs;
    int         gap;
    cs = model_csum(data) ^ (bad ? 8'h01 : 8'h00);
    clear_log();
    pulse_start();
    send_byte(8'(n >> 8), 1'b0);
    send_byte(8'(n & 255), 1'b0);
    foreach (data[i]) begin
      gap = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      repeat (gap) go_idle();
      send_byte(data[i], start_mid && (i == 1));
    end
    send_byte(cs, 1'b0);
    go_idle();
    repeat (3) @(negedge clk);
    checks++;
    if (wr_addr_q.size() != n) begin
      errors++;
      $display("FAIL %s write_count: got %0d required %0d", name, wr_addr_q.size(), n);
    end
    for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
      checks++;
      if (wr_addr_q[i] !== 32'(4 * i) || wr_data_q[i] !== model_word(data, i)) begin
        errors++;
        $display("FAIL %s write[%0d]: got (%h,%h) required (%h,%h)", name, i,
                 wr_addr_q[i], wr_data_q[i], 32'(4 * i), model_word(data, i));
      end
    end
    checks++;
    if (done_cnt != (bad ? 0 : 1)) begin
      errors++;
      $display("FAIL %s done_pulses: got %0d required %0d", name, done_cnt, bad ? 0 : 1);
    end
    checks++;
    if (error !== bad || words_loaded !== 16'(n)) begin
      errors++;
      $display("FAIL %s status: error=%b words=%0d required error=%b words=%0d",
               name, error, words_loaded, bad, n);
    end
    checks++;
    if (busy !== 1'b0 || cpu_hold !== 1'b0 || rx_ready !== 1'b0 || hold_viol != 0) begin
      errors++;
      $display("FAIL %s idle_after: busy=%b hold=%b ready=%b hold_viol=%0d required 0",
               name, busy, cpu_hold, rx_ready, hold_viol);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (2) @(negedge clk);
    checks++;
    if ({rx_ready, imem_we, imem_addr, imem_wdata, cpu_hold, busy, done, error, words_loaded} !== 86'd0) begin
      errors++;
      $display("FAIL reset_state: outputs=%h required 0",
               {rx_ready, imem_we, imem_addr, imem_wdata, cpu_hold, busy, done, error, words_loaded});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_normal();
    logic [7:0] d[$];
    d = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    run_load("normal", d, 2, 1'b0, 0, 1'b0);
    checks++;
    if (wr_data_q.size() != 2 || wr_addr_q[1] !== 32'h4 ||
        wr_data_q[0] !== 32'h12345678 || wr_data_q[1] !== 32'h9ABCDEF0) begin
      errors++;
      $display("FAIL normal_words: got %0d writes required (0,12345678),(4,9abcdef0)", wr_data_q.size());
    end
    run_load("bad_csum", d, 2, 1'b1, 0, 1'b0);
  endtask

  task automatic test_oversize();
    clear_log();
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    @(negedge clk); rx_valid = 1'b0;
    checks++;
    if (error !== 1'b1 || busy !== 1'b0 || rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL oversize: error=%b busy=%b ready=%b required 1,0,0", error, busy, rx_ready);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (wr_addr_q.size() != 0 || done_cnt != 0) begin
      errors++;
      $display("FAIL oversize_writes: writes=%0d done=%0d required 0,0", wr_addr_q.size(), done_cnt);
    end
  endtask

  task automatic test_timeout();
    clear_log();
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    @(negedge clk); rx_valid = 1'b0;
    repeat (15) @(negedge clk);
    checks++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early: error=%b busy=%b at 15 cycles required 0,1", error, busy);
    end
    @(negedge clk);
    checks++;
    if (error !== 1'b1 || rx_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_fire: error=%b ready=%b busy=%b at 16 cycles required 1,0,0",
               error, rx_ready, busy);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (wr_addr_q.size() != 0 || words_loaded !== 16'd0) begin
      errors++;
      $display("FAIL timeout_nowrite: writes=%0d words=%0d required 0", wr_addr_q.size(), words_loaded);
    end
    // A finished word survives a later timeout
    clear_log();
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    for (int i = 0; i < 5; i++) send_byte(8'(8'h40 + i), 1'b0);
    go_idle();
    repeat (TMO + 4) @(negedge clk);
    checks++;
    if (wr_addr_q.size() != 1 || wr_data_q[0] !== 32'h40414243 || words_loaded !== 16'd1 || error !== 1'b1) begin
      errors++;
      $display("FAIL timeout_partial: writes=%0d words=%0d error=%b required 1,1,1",
               wr_addr_q.size(), words_loaded, error);
    end
  endtask

  task automatic test_timeout_edge();
    clear_log();
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'hAA, 1'b0);
    @(negedge clk); rx_valid = 1'b0;
    repeat (14) @(negedge clk);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b0);
    send_byte(8'hDD, 1'b0);
    @(negedge clk); rx_valid = 1'b0;
    checks++;
    if (imem_we !== 1'b1 || imem_addr !== 32'h0 || imem_wdata !== 32'hAABBCCDD || words_loaded !== 16'd1) begin
      errors++;
      $display("FAIL write_latency: we=%b addr=%h data=%h words=%0d required 1,0,aabbccdd,1",
               imem_we, imem_addr, imem_wdata, words_loaded);
    end
    send_byte(8'hAA ^ 8'hBB ^ 8'hCC ^ 8'hDD, 1'b0);
    go_idle();
    repeat (2) @(negedge clk);
    checks++;
    if (done_cnt != 1 || error !== 1'b0) begin
      errors++;
      $display("FAIL timeout_boundary: done=%0d error=%b required 1,0", done_cnt, error);
    end
  endtask

  task automatic test_zero_and_gaps();
    logic [7:0] e[$];
    logic [7:0] d[$];
    logic [31:0] saved[$];
    run_load("zero_len", e, 0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 4; i++) d.push_back(8'($urandom));
    run_load("gapless", d, 1, 1'b0, 0, 1'b0);
    saved = wr_data_q;
    run_load("gapped", d, 1, 1'b0, 1, 1'b0);
    checks++;
    if (saved.size() != 1 || wr_data_q.size() != 1 || saved[0] !== wr_data_q[0]) begin
      errors++;
      $display("FAIL gap_equivalence: gapless %0d writes gapped %0d writes, must match",
               saved.size(), wr_data_q.size());
    end
  endtask

  task automatic test_reset_mid();
    clear_log();
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b0);
    @(negedge clk); rx_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({rx_ready, imem_we, imem_addr, imem_wdata, cpu_hold, busy, done, error, words_loaded} !== 86'd0
        || wr_addr_q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid: outputs=%h writes=%0d required 0",
               {rx_ready, imem_we, imem_addr, imem_wdata, cpu_hold, busy, done, error, words_loaded},
               wr_addr_q.size());
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_start_busy();
    logic [7:0] d[$];
    for (int i = 0; i < 8; i++) d.push_back(8'($urandom));
    run_load("start_busy", d, 2, 1'b0, 0, 1'b1);
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      logic [7:0] d[$];
      int n;
      bit bad;
      n   = int'($urandom_range(1, 6));
      bad = 1'($urandom_range(0, 1));
      for (int i = 0; i < 4 * n; i++) d.push_back(8'($urandom));
      run_load($sformatf("random%0d", it), d, n, bad, 2, 1'b0);
    end
  endtask

  task automatic test_full_depth();
    logic [7:0] d[$];
    for (int i = 0; i < 4 * DEPTH; i++) d.push_back(8'($urandom));
    run_load("full_depth", d, DEPTH, 1'b0, 0, 1'b0);
    checks++;
    if (wr_addr_q.size() != DEPTH || wr_addr_q[DEPTH-1] !== 32'h3FC) begin
      errors++;
      $display("FAIL full_depth_last_addr: writes=%0d required %0d ending at 3fc", wr_addr_q.size(), DEPTH);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_oversize();
    test_timeout();
    test_timeout_edge();
    test_zero_and_gaps();
    test_reset_mid();
    test_start_busy();
    test_random();
    test_full_depth();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
